step_scheduler: RTL
===================

Name: step_scheduler

Overview:
- Schedules snake game-step events from the 10 ms tick produced by the clock divider.
- Converts the free-running tick into a variable-rate step request for the game engine, using a req/ack handshake.
- Step rate rises with difficulty level; level advances with food events.
- Handles start, pause and stop, and counts missed steps (overruns) when the engine is slow to acknowledge.

Parameters:
- BASE_PERIOD, 50: ticks per step at level 0 (500 ms).
- PERIOD_DEC, 5: ticks removed from the period per level.
- MIN_PERIOD, 10: floor on the step period, in ticks.
- MAX_LEVEL, 8: level saturation value.
- FOOD_PER_LEVEL, 4: food events needed per level increment.
- ACK_TIMEOUT, 1000: mclk cycles allowed for step_ack (watchdog only).

Ports:
- mclk  in  1  system clock, 100 MHz.
- clr  in  1  asynchronous active-high reset.
- tick10ms  in  1  one-mclk-cycle pulse every 10 ms.
- start  in  1  pulse; IDLE -> RUN.
- stop  in  1  pulse; any state -> IDLE.
- pause  in  1  level; holds the schedule while high.
- food  in  1  pulse; one food eaten.
- step_ack  in  1  engine has consumed the step.
- step_req  out  1  step pending, registered.
- level  out  4  current difficulty level.
- running  out  1  high in RUN, WAIT_ACK and PAUSED.
- overrun  out  8  missed-step count, saturates at 255.
- timeout  out  1  sticky watchdog flag (WATCHDOG_EN only).

Behaviour:
- Reset (clr=1, asynchronous, overrides all):
  - state=IDLE.
  - step_req=0, level=0, running=0, overrun=0, timeout=0.
  - tick_cnt=0, food_cnt=0.
- period = max(BASE_PERIOD - level*PERIOD_DEC, MIN_PERIOD).
  - Computed combinationally, 8-bit unsigned.
  - Subtraction is done in signed or wider arithmetic so it never underflows.
- State IDLE:
  - start -> RUN; clears tick_cnt, food_cnt, level and overrun.
  - All other inputs are ignored.
- State RUN:
  - pause=1 -> PAUSED, with tick_cnt held. Pause beats a simultaneous tick, which is discarded.
  - Otherwise, on tick10ms:
    - if tick_cnt >= period-1: tick_cnt<=0, step_req<=1, -> WAIT_ACK.
    - else: tick_cnt+1.
  - The >= compare means a period shortened by a level-up fires on the next tick.
- State WAIT_ACK:
  - step_req stays high until step_ack.
  - step_ack -> step_req<=0 next cycle, -> RUN.
  - tick10ms still advances tick_cnt. If it hits period-1 before ack: overrun+1 (saturating), tick_cnt<=0, no second request.
  - Simultaneous ack and tick: both take effect.
  - pause is deferred until ack; then RUN, which sees pause and goes to PAUSED.
- State PAUSED:
  - pause=0 -> RUN.
  - tick10ms and food are ignored.
- step_ack outside WAIT_ACK is ignored.
- Food handling (RUN and WAIT_ACK only):
  - food: if food_cnt == FOOD_PER_LEVEL-1, food_cnt<=0 and level+1, saturating at MAX_LEVEL; else food_cnt+1.
- stop (any state): -> IDLE, step_req<=0, running<=0. level and overrun hold their values for score display.
- Priority within one cycle: stop > pause > tick > food. food and tick in the same cycle are both applied.
- Latency:
  - Tick that completes the period -> step_req high on the next mclk edge.
  - step_ack -> step_req low on the next edge.
- start while not IDLE is ignored.

Optional Feature:
- Macro: STEP_SCHED_WATCHDOG_EN.
- When defined:
  - A 10-bit cycle counter runs during WAIT_ACK.
  - On reaching ACK_TIMEOUT-1 without ack: step_req<=0, timeout<=1 (sticky until clr or start), -> RUN.
- When undefined:
  - The timeout port is tied to 0 and no counter is built.
  - WAIT_ACK waits indefinitely.

Decomposition:
- Shared package (snake_pkg):
  - state encoding: IDLE=2'd0, RUN=2'd1, WAIT_ACK=2'd2, PAUSED=2'd3.
  - TICK_W=8.
  - Default period constants, shared with the game engine.
- One sub-module, period_lut: level -> period. Purely combinational, parameterised as above.

Test Plan:
- Level 0, no ack delay: clr, start, ack 1 cycle after req -> step_req rises on the edge after every 50th tick10ms; overrun=0.
- 4 food pulses -> level=1, next step after 45 ticks. 36 food -> level saturates at 8; period=max(50-40,10)=10.
- Withhold ack for 120 ticks at level 0 -> step_req stays high, overrun=2, single request; ack -> back to RUN.
- Pause at tick_cnt=30 for 200 ticks, then release -> step fires 20 ticks after release.
- Stop and pause asserted with tick in the same cycle -> IDLE, step_req=0, level retained; clr mid-WAIT_ACK -> all outputs 0 immediately.
- With STEP_SCHED_WATCHDOG_EN defined, no ack for 1000 cycles -> step_req falls, timeout=1 until start.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared definitions for the snake game: scheduler state encoding,
// tick counter width and the default step-period constants that the
// game engine also uses.
package snake_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    WAIT_ACK = 2'd2,
    PAUSED   = 2'd3
  } state_t;

  localparam int TICK_W = 8;

  // Default step timing, in 10 ms ticks unless noted.
  localparam int DEF_BASE_PERIOD    = 50;
  localparam int DEF_PERIOD_DEC     = 5;
  localparam int DEF_MIN_PERIOD     = 10;
  localparam int DEF_MAX_LEVEL      = 8;
  localparam int DEF_FOOD_PER_LEVEL = 4;
  localparam int DEF_ACK_TIMEOUT    = 1000;  // mclk cycles

endpackage

// File: rtl/step_scheduler_period_lut.sv
// Purpose: maps difficulty level to step period in ticks, floored at MIN_PERIOD.
// Latency: purely combinational.
// Backpressure: none.
// Ports: level (4b) in, period (TICK_W) out.
module period_lut
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD = DEF_BASE_PERIOD,
  parameter int PERIOD_DEC  = DEF_PERIOD_DEC,
  parameter int MIN_PERIOD  = DEF_MIN_PERIOD
) (
  input  logic [3:0]        level,
  output logic [TICK_W-1:0] period
);

  // 12-bit signed keeps BASE - 15*DEC from wrapping before the floor compare.
  logic signed [11:0] raw;

  always_comb begin
    raw = $signed(12'(BASE_PERIOD)) - $signed({8'd0, level}) * $signed(12'(PERIOD_DEC));
    if (raw < $signed(12'(MIN_PERIOD))) begin
      period = TICK_W'(MIN_PERIOD);
    end else begin
      period = TICK_W'(raw);
    end
  end

endmodule

// File: rtl/step_scheduler.sv
// Purpose: turns the free-running 10 ms tick into level-dependent game-step requests.
// Latency: period-completing tick -> step_req next edge; step_ack -> step_req low next edge.
// Backpressure: req/ack; a slow ack counts overruns instead of queuing extra requests.
// Ports: mclk, clr (async, active high), tick10ms, start, stop, pause, food, step_ack in;
//        step_req, level[3:0], running, overrun[7:0], timeout out.
// Optional: define STEP_SCHED_WATCHDOG_EN for the ack watchdog; otherwise timeout is 0.
module step_scheduler
  import snake_pkg::*;
#(
  parameter int BASE_PERIOD    = DEF_BASE_PERIOD,
  parameter int PERIOD_DEC     = DEF_PERIOD_DEC,
  parameter int MIN_PERIOD     = DEF_MIN_PERIOD,
  parameter int MAX_LEVEL      = DEF_MAX_LEVEL,
  parameter int FOOD_PER_LEVEL = DEF_FOOD_PER_LEVEL
`ifdef STEP_SCHED_WATCHDOG_EN
  ,
  parameter int ACK_TIMEOUT    = DEF_ACK_TIMEOUT
`endif
) (
  input  logic       mclk,
  input  logic       clr,
  input  logic       tick10ms,
  input  logic       start,
  input  logic       stop,
  input  logic       pause,
  input  logic       food,
  input  logic       step_ack,
  output logic       step_req,
  output logic [3:0] level,
  output logic       running,
  output logic [7:0] overrun,
  output logic       timeout
);

  state_t            state_q, state_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]        food_cnt_q, food_cnt_d;
  logic [3:0]        level_q, level_d;
  logic [7:0]        overrun_q, overrun_d;
  logic              step_req_q, step_req_d;

  logic [TICK_W-1:0] period;
  logic              tick_hit;
  logic [3:0]        food_cnt_eat, level_eat;

`ifdef STEP_SCHED_WATCHDOG_EN
  logic              timeout_q, timeout_d;
  logic [9:0]        wd_cnt_q, wd_cnt_d;
`endif

  period_lut #(
    .BASE_PERIOD (BASE_PERIOD),
    .PERIOD_DEC  (PERIOD_DEC),
    .MIN_PERIOD  (MIN_PERIOD)
  ) u_period_lut (
    .level  (level_q),
    .period (period)
  );

  // >= rather than == so a period shortened by a level-up fires on the next tick.
  assign tick_hit = (tick_cnt_q >= (period - TICK_W'(1)));

  // Result of one food event, applied only where food is honoured.
  always_comb begin
    food_cnt_eat = food_cnt_q + 4'd1;
    level_eat    = level_q;
    if (food_cnt_q == 4'(FOOD_PER_LEVEL - 1)) begin
      food_cnt_eat = '0;
      if (level_q != 4'(MAX_LEVEL)) begin
        level_eat = level_q + 4'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    food_cnt_d = food_cnt_q;
    level_d    = level_q;
    overrun_d  = overrun_q;
    step_req_d = step_req_q;
`ifdef STEP_SCHED_WATCHDOG_EN
    timeout_d  = timeout_q;
    wd_cnt_d   = (state_q == WAIT_ACK) ? wd_cnt_q + 10'd1 : '0;
`endif

    // stop outranks everything; level and overrun stay for the score display.
    if (stop) begin
      state_d    = IDLE;
      step_req_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d    = RUN;
            tick_cnt_d = '0;
            food_cnt_d = '0;
            level_d    = '0;
            overrun_d  = '0;
`ifdef STEP_SCHED_WATCHDOG_EN
            timeout_d  = 1'b0;
`endif
          end
        end

        RUN: begin
          // pause discards a coincident tick and food
          if (pause) begin
            state_d = PAUSED;
          end else begin
            if (tick10ms) begin
              if (tick_hit) begin
                tick_cnt_d = '0;
                step_req_d = 1'b1;
                state_d    = WAIT_ACK;
              end else begin
                tick_cnt_d = tick_cnt_q + TICK_W'(1);
              end
            end
            if (food) begin
              food_cnt_d = food_cnt_eat;
              level_d    = level_eat;
            end
          end
        end

        WAIT_ACK: begin
          // pause is ignored here; RUN picks it up after the ack.
          if (step_ack) begin
            step_req_d = 1'b0;
            state_d    = RUN;
`ifdef STEP_SCHED_WATCHDOG_EN
          end else if (wd_cnt_q == 10'(ACK_TIMEOUT - 1)) begin
            step_req_d = 1'b0;
            timeout_d  = 1'b1;
            state_d    = RUN;
`endif
          end
          // Ticks keep the schedule; a full period without ack is a missed step.
          if (tick10ms) begin
            if (tick_hit) begin
              tick_cnt_d = '0;
              if (overrun_q != 8'hFF) begin
                overrun_d = overrun_q + 8'd1;
              end
            end else begin
              tick_cnt_d = tick_cnt_q + TICK_W'(1);
            end
          end
          if (food) begin
            food_cnt_d = food_cnt_eat;
            level_d    = level_eat;
          end
        end

        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      food_cnt_q <= '0;
      level_q    <= '0;
      overrun_q  <= '0;
      step_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      food_cnt_q <= food_cnt_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
      step_req_q <= step_req_d;
    end
  end

`ifdef STEP_SCHED_WATCHDOG_EN
  always_ff @(posedge mclk or posedge clr) begin
    if (clr) begin
      timeout_q <= 1'b0;
      wd_cnt_q  <= '0;
    end else begin
      timeout_q <= timeout_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end
  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign step_req = step_req_q;
  assign level    = level_q;
  assign overrun  = overrun_q;
  assign running  = (state_q != IDLE);

endmodule
